// File: rtl/imm_gen_pipe.sv
// Registered RISC-V immediate generator (I/S/B/U/J/shift, XLEN 32|64) with tag sideband; optional IMM_ILLEGAL_EN adds out_illegal.
// Latency: 1 cycle from input transfer to out_valid; main register plus skid register.
// Backpressure: full throughput; in_ready drops only while the skid register holds an entry.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic [TAG_W-1:0] out_tag
`ifdef IMM_ILLEGAL_EN
    ,
    output logic             out_illegal
`endif
);

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("imm_gen_pipe: XLEN must be 32 or 64");
    end

    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;
    localparam logic [2:0] FMT_SH   = 3'd6;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [2:0]       fmt;
        logic [TAG_W-1:0] tag;
`ifdef IMM_ILLEGAL_EN
        logic             ill;
`endif
    } entry_t;

    entry_t     dec;
    entry_t     main_q;
    entry_t     skid_q;
    logic       main_vld;
    logic       skid_vld;
    logic       in_fire;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       is_shift;
`ifdef IMM_ILLEGAL_EN
    logic       sh_hi_ok;
`endif

    assign opcode   = in_inst[6:0];
    assign funct3   = in_inst[14:12];
    assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

    always_comb begin
        dec     = '0;
        dec.tag = in_tag;
        case (opcode)
            OP_IMM: begin
                if (is_shift) begin
                    dec.fmt = FMT_SH;
                    if (XLEN == 64) dec.imm = XLEN'(in_inst[25:20]);
                    else            dec.imm = XLEN'(in_inst[24:20]);
                end else begin
                    dec.fmt = FMT_I;
                    dec.imm = XLEN'($signed(in_inst[31:20]));
                end
            end
            OP_LOAD, OP_JALR: begin
                dec.fmt = FMT_I;
                dec.imm = XLEN'($signed(in_inst[31:20]));
            end
            OP_IMM32: begin
                // Word-sized immediates only exist on RV64; RV32 treats the opcode as unknown.
                if (XLEN == 64) begin
                    if (is_shift) begin
                        dec.fmt = FMT_SH;
                        dec.imm = XLEN'(in_inst[24:20]);
                    end else begin
                        dec.fmt = FMT_I;
                        dec.imm = XLEN'($signed(in_inst[31:20]));
                    end
                end
            end
            OP_STORE: begin
                dec.fmt = FMT_S;
                dec.imm = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
            end
            OP_BRANCH: begin
                dec.fmt = FMT_B;
                dec.imm = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25],
                                         in_inst[11:8], 1'b0}));
            end
            OP_LUI, OP_AUIPC: begin
                dec.fmt = FMT_U;
                dec.imm = XLEN'($signed({in_inst[31:12], 12'b0}));
            end
            OP_JAL: begin
                dec.fmt = FMT_J;
                dec.imm = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20],
                                         in_inst[30:21], 1'b0}));
            end
            default: begin
                dec.fmt = FMT_NONE;
            end
        endcase
`ifdef IMM_ILLEGAL_EN
        sh_hi_ok = 1'b0;
        if (XLEN == 64 && opcode == OP_IMM)
            sh_hi_ok = (in_inst[31:26] == 6'b000000) || (in_inst[31:26] == 6'b010000);
        else
            sh_hi_ok = (in_inst[31:25] == 7'b0000000) || (in_inst[31:25] == 7'b0100000);
        dec.ill = (dec.fmt == FMT_NONE) ||
                  ((dec.fmt == FMT_SH) && (!sh_hi_ok || (funct3 == 3'b001 && in_inst[30])));
`endif
    end

    assign in_fire = in_valid && !skid_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
            main_q   <= '0;
            skid_q   <= '0;
        end else if (flush) begin
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
        end else if (!main_vld || out_ready) begin
            // Main is free this edge: refill from skid first to preserve order.
            if (skid_vld) begin
                main_q   <= skid_q;
                main_vld <= 1'b1;
                skid_vld <= 1'b0;
            end else begin
                main_vld <= in_fire;
                if (in_fire) main_q <= dec;
            end
        end else if (in_fire) begin
            skid_q   <= dec;
            skid_vld <= 1'b1;
        end
    end

    assign in_ready  = !skid_vld;
    assign out_valid = main_vld;
    assign out_imm   = main_q.imm;
    assign out_fmt   = main_q.fmt;
    assign out_tag   = main_q.tag;
`ifdef IMM_ILLEGAL_EN
    assign out_illegal = main_q.ill;
`endif

endmodule
